// File: rtl/img_pkg.sv
// Shared constants and types for the image-processing stage.
// Defaults match the full-size frame; the core overrides per instance.
package img_pkg;

  localparam int IMG_WIDTH_D  = 2560;
  localparam int IMG_HEIGHT_D = 1440;
  localparam int DATA_WIDTH_D = 8;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int X_W_D = cnt_w(IMG_WIDTH_D);
  localparam int Y_W_D = cnt_w(IMG_HEIGHT_D);

endpackage

// File: rtl/img_pixel_op.sv
// Per-pixel operation: bypass or binary threshold.
// Purely combinational.
module img_pixel_op
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D
) (
  input  logic [DATA_WIDTH-1:0] raw,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic [DATA_WIDTH-1:0] pixel
);

  always_comb begin
    pixel = raw;
    if (mode)
      pixel = (raw >= threshold) ? '1 : '0;
  end

endmodule

// File: rtl/img_process_core.sv
// Test-pattern source with per-pixel op and AXI4-Stream video output.
// Outputs are registered from the coordinates of the next pixel.
module img_process_core
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_D,
  parameter int IMG_HEIGHT = IMG_HEIGHT_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  localparam int XW = cnt_w(IMG_WIDTH);
  localparam int YW = cnt_w(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  state_t                  state;
  logic [XW-1:0]           x, nx;
  logic [YW-1:0]           y, ny;
  logic [DATA_WIDTH-1:0]   f, nf;
  logic                    mode_q;
  logic [DATA_WIDTH-1:0]   thr_q;

  logic                    xfer, eol, eof, start;
  logic                    sel_mode;
  logic [DATA_WIDTH-1:0]   sel_thr, raw, pix;

  assign xfer  = (state == RUN) && m_axis_tvalid && m_axis_tready;
  assign eol   = (x == X_LAST);
  assign eof   = eol && (y == Y_LAST);
  assign start = ((state == IDLE) && enable)
               || (xfer && eof && enable);

  always_comb begin
    nx = x;
    ny = y;
    nf = f;
    if (state == IDLE) begin
      nx = '0;
      ny = '0;
    end else if (eof) begin
      nx = '0;
      ny = '0;
      nf = f + 1'b1;
    end else if (eol) begin
      nx = '0;
      ny = y + 1'b1;
    end else begin
      nx = x + 1'b1;
    end
  end

  // A new frame picks up live mode/threshold; mid-frame uses the latched copy
  assign sel_mode = start ? mode : mode_q;
  assign sel_thr  = start ? threshold : thr_q;
  assign raw = DATA_WIDTH'(nx) + DATA_WIDTH'(ny) + nf;

  img_pixel_op #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_op (
    .raw      (raw),
    .mode     (sel_mode),
    .threshold(sel_thr),
    .pixel    (pix)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      f             <= '0;
      mode_q        <= 1'b0;
      thr_q         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frame_done    <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state         <= RUN;
            mode_q        <= mode;
            thr_q         <= threshold;
            x             <= nx;
            y             <= ny;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= pix;
            m_axis_tuser  <= 1'b1;
            m_axis_tlast  <= (nx == X_LAST);
          end
        end
        RUN: begin
          if (xfer) begin
            x            <= nx;
            y            <= ny;
            f            <= nf;
            m_axis_tdata <= pix;
            m_axis_tuser <= (nx == '0) && (ny == '0);
            m_axis_tlast <= (nx == X_LAST);
            if (eof) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 1'b1;
              if (enable) begin
                mode_q <= mode;
                thr_q  <= threshold;
              end else begin
                state         <= IDLE;
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
                m_axis_tuser  <= 1'b0;
                m_axis_tlast  <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_process_core.sv
// Directed bench for img_process_core: 4x2 frames plus a 260x3
// instance that exercises pixel-value wrap past 255.
module tb_img_process_core;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable, mode, tready;
  logic [7:0] threshold;
  logic [7:0] tdata;
  logic       tvalid, tlast, tuser, frame_done;
  logic [15:0] frame_cnt;

  logic       enable2;
  logic [7:0] tdata2;
  logic       tvalid2, tlast2, tuser2, frame_done2;
  logic [15:0] frame_cnt2;

  always #5 clk = ~clk;

  img_process_core #(
    .IMG_WIDTH(4), .IMG_HEIGHT(2), .DATA_WIDTH(8)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .mode(mode), .threshold(threshold),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast),
    .m_axis_tuser(tuser), .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  img_process_core #(
    .IMG_WIDTH(260), .IMG_HEIGHT(3), .DATA_WIDTH(8)
  ) dut2 (
    .clk(clk), .resetn(resetn), .enable(enable2),
    .mode(1'b0), .threshold(8'd0),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2),
    .m_axis_tready(1'b1), .m_axis_tlast(tlast2),
    .m_axis_tuser(tuser2), .frame_done(frame_done2),
    .frame_cnt(frame_cnt2)
  );

  typedef struct {
    logic [7:0] d;
    logic       u;
    logic       l;
    int         c;
  } xfer_t;

  xfer_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int n2 = 0;
  logic [7:0] d2_256, d2_last;
  logic       l2_last;
  logic       stalled = 1'b0;
  logic [10:0] held;

  logic [7:0] f0  [8] = '{0, 1, 2, 3, 1, 2, 3, 4};
  logic [7:0] thr [8] = '{0, 0, 255, 255, 0, 255, 255, 255};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (resetn) begin
      if (frame_done) done_cnt++;
      if (stalled)
        chk("stall_hold", {tvalid, tuser, tlast, tdata}, held);
      stalled = tvalid && !tready;
      held = {1'b1, tuser, tlast, tdata};
      if (tvalid && tready)
        q.push_back('{d: tdata, u: tuser, l: tlast, c: cyc});
      if (tvalid2) begin
        if (n2 == 256) d2_256 = tdata2;
        d2_last = tdata2;
        l2_last = tlast2;
        n2++;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic wait_q(input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q.size() < n) chk("timeout_q", q.size(), n);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    enable = 1'b0;
    enable2 = 1'b0;
    mode = 1'b0;
    threshold = 8'd0;
    tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {tvalid, tuser, tlast, frame_done, tdata}, 12'h000);
    chk("rst_cnt", frame_cnt, 16'd0);
    q.delete();
    done_cnt = 0;
    resetn = 1'b1;
  endtask

  task automatic chk_frame(input string tag, input int base, input int f,
                           input logic tmode);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_d"}, q[base + i].d, tmode ? thr[i] : f0[i] + 8'(f));
      chk({tag, "_ul"}, {q[base + i].u, q[base + i].l},
          {i == 0, (i % 4) == 3});
    end
  endtask

  initial begin
    int k;
    do_reset();

    // bypass, continuous frames, latency and no inter-frame gap
    enable = 1'b1;
    @(negedge clk);
    chk("lat_before", tvalid, 1'b0);
    @(negedge clk);
    chk("lat_after", {tvalid, tuser, tdata}, {1'b1, 1'b1, 8'd0});
    wait_q(16, 40);
    if (q.size() >= 16) begin
      chk_frame("a0", 0, 0, 1'b0);
      chk_frame("a1", 8, 1, 1'b0);
      chk("a_nogap", q[8].c, q[7].c + 1);
    end
    repeat (3) @(negedge clk);
    chk("a_fcnt", frame_cnt, 16'd2);
    chk("a_done", done_cnt, 2);

    // threshold, enable dropped mid-frame, live mode/threshold changes
    do_reset();
    mode = 1'b1;
    threshold = 8'd2;
    enable = 1'b1;
    wait_q(3, 20);
    enable = 1'b0;
    mode = 1'b0;
    threshold = 8'd0;
    repeat (20) @(negedge clk);
    chk("b_n", q.size(), 8);
    if (q.size() >= 8) chk_frame("b", 0, 0, 1'b1);
    chk("b_done", done_cnt, 1);
    chk("b_fcnt", frame_cnt, 16'd1);
    chk("b_idle", tvalid, 1'b0);

    // random backpressure on a single frame
    do_reset();
    enable = 1'b1;
    k = 0;
    repeat (150) begin
      @(posedge clk);
      #1;
      tready = 1'($urandom_range(0, 1));
      k++;
      if (k == 3) enable = 1'b0;
    end
    tready = 1'b1;
    repeat (10) @(negedge clk);
    chk("c_n", q.size(), 8);
    if (q.size() >= 8) chk_frame("c", 0, 0, 1'b0);
    chk("c_done", done_cnt, 1);
    chk("c_fcnt", frame_cnt, 16'd1);
    chk("c_idle", tvalid, 1'b0);

    // asynchronous reset mid-frame
    do_reset();
    enable = 1'b1;
    wait_q(3, 20);
    #2;
    resetn = 1'b0;
    #1;
    chk("d_async", {tvalid, tuser, tlast, frame_done, tdata}, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    chk("d_fcnt", frame_cnt, 16'd0);
    chk("d_done", done_cnt, 0);
    q.delete();
    resetn = 1'b1;
    wait_q(1, 10);
    if (q.size() >= 1) chk("d_restart", {q[0].u, q[0].d}, {1'b1, 8'd0});
    enable = 1'b0;
    repeat (12) @(negedge clk);

    // 260x3 frame: pixel values wrap modulo 256
    n2 = 0;
    enable2 = 1'b1;
    @(posedge clk);
    #1;
    enable2 = 1'b0;
    k = 0;
    while (!frame_done2 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("e_pulse", frame_done2, 1'b1);
    chk("e_n", n2, 780);
    chk("e_x256", d2_256, 8'd0);
    chk("e_last", {l2_last, d2_last}, {1'b1, 8'd5});
    chk("e_fcnt", frame_cnt2, 16'd1);
    @(negedge clk);
    chk("e_idle", {tvalid2, frame_done2}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
